// File: rtl/regfile_sched_pkg.sv
// Shared types for the register-file write-port scheduler.
// Write sources, the write request bundle and hold-slot states.
package regfile_sched_pkg;

  localparam int RF_REG_W  = 5;
  localparam int RF_DATA_W = 64;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_HOLD,
    WB_LU
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [RF_REG_W-1:0]  rd;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } hold_st_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard for long-latency destinations.
// Gates issue on RAW/WAW hazards and on the outstanding-op limit.
module rf_scoreboard
  import regfile_sched_pkg::*;
#(
  parameter int REG_W    = RF_REG_W,
  parameter int MAX_LONG = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_long,
  output logic             issue_ready,
  input  logic             commit,
  input  logic [REG_W-1:0] commit_rd,
  output logic [31:0]      busy,
  output logic [3:0]       pending_cnt,
  output logic             sb_err
);

  logic        cap_full;
  logic        fire;
  logic        inc;
  logic        dec;
  logic [31:0] set_m;
  logic [31:0] clr_m;

  assign cap_full = (pending_cnt == 4'(MAX_LONG));

  assign issue_ready =
    !(issue_use_rs1 && busy[issue_rs1]) &&
    !(issue_use_rs2 && busy[issue_rs2]) &&
    !busy[issue_rd] &&
    !(issue_long && cap_full);

  assign fire = issue_valid && issue_ready && issue_long;
  assign inc  = fire;
  // Saturate so a stray commit cannot wrap the counter.
  assign dec  = commit && (pending_cnt != 4'd0);

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (fire)   set_m[issue_rd]  = 1'b1;
    if (commit) clr_m[commit_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy        <= '0;
      pending_cnt <= '0;
      sb_err      <= 1'b0;
    end else begin
      busy <= (busy | set_m) & ~clr_m & ~32'd1;
      unique case ({inc, dec})
        2'b10:   pending_cnt <= pending_cnt + 4'd1;
        2'b01:   pending_cnt <= pending_cnt - 4'd1;
        default: pending_cnt <= pending_cnt;
      endcase
      if (commit && commit_rd != '0 &&
          !busy[commit_rd])
        sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Single write-port arbiter: ALU > held long result > long unit.
// Write-port outputs are registered; the regfile captures on negedge.
module regfile_wb_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int REG_W    = RF_REG_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int MAX_LONG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rs1,
  input  logic [REG_W-1:0]  issue_rs2,
  input  logic              issue_use_rs1,
  input  logic              issue_use_rs2,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic              issue_long,
  output logic              issue_ready,
  input  logic              alu_wb_valid,
  input  logic [REG_W-1:0]  alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              lu_wb_valid,
  input  logic [REG_W-1:0]  lu_wb_rd,
  input  logic [DATA_W-1:0] lu_wb_data,
  output logic              lu_wb_ready,
  output logic              RegWrite,
  output logic [REG_W-1:0]  Writeregister,
  output logic [DATA_W-1:0] Writedata,
  output logic [31:0]       busy,
  output logic [3:0]        pending_cnt,
  output logic              sb_err
);

  hold_st_e         hold_st;
  wb_req_t          hold_q;
  wb_src_e          sel;
  wb_req_t          pick;
  logic             hold_full;
  logic             lu_fire;
  logic             commit_q;
  logic [REG_W-1:0] commit_rd_q;

  assign hold_full   = (hold_st == HOLD_FULL);
  assign lu_wb_ready = !hold_full;
  assign lu_fire     = lu_wb_valid && !hold_full;

  always_comb begin
    sel = WB_NONE;
    unique case (1'b1)
      alu_wb_valid:               sel = WB_ALU;
      hold_full && !alu_wb_valid: sel = WB_HOLD;
      lu_fire && !alu_wb_valid:   sel = WB_LU;
      default:                    sel = WB_NONE;
    endcase
  end

  always_comb begin
    pick = '0;
    unique case (sel)
      WB_ALU:  pick = '{1'b1, alu_wb_rd, alu_wb_data};
      WB_HOLD: pick = hold_q;
      WB_LU:   pick = '{1'b1, lu_wb_rd, lu_wb_data};
      default: pick = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_st       <= HOLD_EMPTY;
      hold_q        <= '0;
      RegWrite      <= 1'b0;
      Writeregister <= '0;
      Writedata     <= '0;
      commit_q      <= 1'b0;
      commit_rd_q   <= '0;
    end else begin
      unique case (hold_st)
        HOLD_EMPTY:
          if (lu_fire && alu_wb_valid) begin
            hold_st <= HOLD_FULL;
            hold_q  <= '{1'b1, lu_wb_rd, lu_wb_data};
          end
        HOLD_FULL:
          if (!alu_wb_valid) begin
            hold_st      <= HOLD_EMPTY;
            hold_q.valid <= 1'b0;
          end
        default: hold_st <= HOLD_EMPTY;
      endcase
      RegWrite <= pick.valid && (pick.rd != '0);
      if (pick.valid) begin
        Writeregister <= pick.rd;
        Writedata     <= pick.data;
      end
      // Long results retire in the cycle their write is presented.
      commit_q    <= (sel == WB_HOLD) || (sel == WB_LU);
      commit_rd_q <= pick.rd;
    end
  end

  rf_scoreboard #(
    .REG_W    (REG_W),
    .MAX_LONG (MAX_LONG)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_rd      (issue_rd),
    .issue_long    (issue_long),
    .issue_ready   (issue_ready),
    .commit        (commit_q),
    .commit_rd     (commit_rd_q),
    .busy          (busy),
    .pending_cnt   (pending_cnt),
    .sb_err        (sb_err)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: hazard table plus write scoreboard.
// Expected writes carry the cycle in which RegWrite must be seen.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic [4:0]  issue_rd;
  logic        issue_long;
  logic        issue_ready;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [63:0] alu_wb_data;
  logic        lu_wb_valid;
  logic [4:0]  lu_wb_rd;
  logic [63:0] lu_wb_data;
  logic        lu_wb_ready;
  logic        RegWrite;
  logic [4:0]  Writeregister;
  logic [63:0] Writedata;
  logic [31:0] busy;
  logic [3:0]  pending_cnt;
  logic        sb_err;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic       u1;
    logic [4:0] rs1;
    logic       u2;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       lng;
    logic       rdy;
  } hz_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } al_t;

  wr_t exp_q[$];
  hz_t hz[8];
  al_t alu_tab[5];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  n;
  int  m;

  regfile_wb_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_rd      (issue_rd),
    .issue_long    (issue_long),
    .issue_ready   (issue_ready),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_rd     (alu_wb_rd),
    .alu_wb_data   (alu_wb_data),
    .lu_wb_valid   (lu_wb_valid),
    .lu_wb_rd      (lu_wb_rd),
    .lu_wb_data    (lu_wb_data),
    .lu_wb_ready   (lu_wb_ready),
    .RegWrite      (RegWrite),
    .Writeregister (Writeregister),
    .Writedata     (Writedata),
    .busy          (busy),
    .pending_cnt   (pending_cnt),
    .sb_err        (sb_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd,
                           input logic [63:0] d,
                           input int c);
    wr_t e;
    e.rd = rd;
    e.data = d;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_rs1     = '0;
    issue_rs2     = '0;
    issue_use_rs1 = 1'b0;
    issue_use_rs2 = 1'b0;
    issue_rd      = '0;
    issue_long    = 1'b0;
    alu_wb_valid  = 1'b0;
    alu_wb_rd     = '0;
    alu_wb_data   = '0;
    lu_wb_valid   = 1'b0;
    lu_wb_rd      = '0;
    lu_wb_data    = '0;
  endtask

  task automatic issue(input logic [4:0] rd,
                       input logic lng);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_long  = lng;
  endtask

  task automatic lu(input logic [4:0] rd,
                    input logic [63:0] d);
    lu_wb_valid = 1'b1;
    lu_wb_rd    = rd;
    lu_wb_data  = d;
  endtask

  task automatic alu(input logic [4:0] rd,
                     input logic [63:0] d);
    alu_wb_valid = 1'b1;
    alu_wb_rd    = rd;
    alu_wb_data  = d;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_write: got rd=%0d data=%h, want none (cyc %0d)",
                 Writeregister, Writedata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rd", 64'(Writeregister), 64'(e.rd));
        chk("wr_data", Writedata, e.data);
        chk("wr_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    hz[0] = '{0, 0, 0, 0, 9, 1, 0};
    hz[1] = '{0, 0, 0, 0, 9, 0, 1};
    hz[2] = '{1, 2, 0, 0, 9, 0, 0};
    hz[3] = '{0, 2, 0, 0, 9, 0, 1};
    hz[4] = '{0, 0, 1, 4, 9, 0, 0};
    hz[5] = '{0, 0, 0, 0, 3, 0, 0};
    hz[6] = '{1, 0, 1, 5, 9, 0, 1};
    hz[7] = '{1, 9, 1, 8, 0, 1, 0};
    alu_tab[0] = '{5'd1,  64'h0123_4567_89ab_cdef};
    alu_tab[1] = '{5'd0,  64'hdead_beef_dead_beef};
    alu_tab[2] = '{5'd31, 64'hffff_ffff_ffff_ffff};
    alu_tab[3] = '{5'd17, 64'h0};
    alu_tab[4] = '{5'd2,  64'h8000_0000_0000_0001};

    // Reset with both write sources active.
    idle();
    reset = 1'b0;
    alu(3, 64'h1);
    lu(4, 64'h2);
    tick();
    mid();
    chk("rst_regwrite_in", 64'(RegWrite), 0);
    tick();
    idle();
    reset = 1'b1;
    mid();
    chk("rst_regwrite", 64'(RegWrite), 0);
    chk("rst_wreg", 64'(Writeregister), 0);
    chk("rst_wdata", Writedata, 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_pend", 64'(pending_cnt), 0);
    chk("rst_lu_ready", 64'(lu_wb_ready), 1);
    chk("rst_sb_err", 64'(sb_err), 0);
    chk("rst_issue_rdy", 64'(issue_ready), 1);
    tick();

    // ALU stream, including an x0 write.
    foreach (alu_tab[i]) begin
      idle();
      alu(alu_tab[i].rd, alu_tab[i].data);
      if (alu_tab[i].rd != 0)
        expect_wr(alu_tab[i].rd, alu_tab[i].data, cyc + 1);
      mid();
      tick();
    end
    idle();
    mid();
    tick();

    // RAW stall on a long destination.
    issue(5, 1);
    mid();
    chk("raw_issue_rdy", 64'(issue_ready), 1);
    tick();
    idle();
    issue(6, 0);
    issue_use_rs1 = 1'b1;
    issue_rs1 = 5;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("raw_stall", 64'(issue_ready), 0);
      tick();
    end
    lu(5, 64'hAA);
    expect_wr(5, 64'hAA, cyc + 1);
    mid();
    chk("raw_stall_n", 64'(issue_ready), 0);
    tick();
    lu_wb_valid = 1'b0;
    mid();
    chk("raw_stall_n1", 64'(issue_ready), 0);
    tick();
    mid();
    chk("raw_ready_n2", 64'(issue_ready), 1);
    chk("raw_busy", 64'(busy), 0);
    tick();
    idle();

    // ALU / long-unit collision.
    issue(7, 1);
    mid();
    tick();
    idle();
    alu(3, 64'h11);
    lu(7, 64'h22);
    n = cyc;
    expect_wr(3, 64'h11, n + 1);
    mid();
    chk("col_lu_ready_n", 64'(lu_wb_ready), 1);
    tick();
    idle();
    expect_wr(7, 64'h22, n + 2);
    mid();
    chk("col_lu_ready_n1", 64'(lu_wb_ready), 0);
    tick();
    mid();
    chk("col_lu_ready_n2", 64'(lu_wb_ready), 1);
    tick();
    issue(7, 1);
    mid();
    chk("col_reissue_rdy", 64'(issue_ready), 1);
    tick();
    idle();
    m = cyc;
    for (int k = 0; k < 5; k++) begin
      alu(5'(10 + k), 64'(256 + k));
      expect_wr(5'(10 + k), 64'(256 + k), cyc + 1);
      if (k == 0) lu(7, 64'h33);
      else lu(7, 64'h99);
      mid();
      chk("defer_lu_ready", 64'(lu_wb_ready),
          (k == 0) ? 64'd1 : 64'd0);
      tick();
    end
    idle();
    lu(7, 64'h99);
    expect_wr(7, 64'h33, m + 6);
    mid();
    chk("defer_lu_ready_5", 64'(lu_wb_ready), 0);
    tick();
    idle();
    mid();
    chk("defer_lu_ready_6", 64'(lu_wb_ready), 1);
    tick();
    mid();
    chk("defer_busy", 64'(busy), 0);
    tick();

    // Outstanding-op capacity.
    for (int k = 0; k < 4; k++) begin
      idle();
      issue(5'(k + 1), 1);
      mid();
      chk("cap_issue_rdy", 64'(issue_ready), 1);
      tick();
    end
    idle();
    mid();
    chk("cap_pend", 64'(pending_cnt), 4);
    chk("cap_busy", 64'(busy), 64'h1E);
    foreach (hz[i]) begin
      issue_use_rs1 = hz[i].u1;
      issue_rs1     = hz[i].rs1;
      issue_use_rs2 = hz[i].u2;
      issue_rs2     = hz[i].rs2;
      issue_rd      = hz[i].rd;
      issue_long    = hz[i].lng;
      #1;
      chk($sformatf("hz%0d", i),
          64'(issue_ready), 64'(hz[i].rdy));
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      idle();
      lu(5'(k + 1), 64'(64 + k));
      expect_wr(5'(k + 1), 64'(64 + k), cyc + 1);
      if (k == 2) issue(6, 1);
      mid();
      if (k == 2)
        chk("cap_inc_dec_rdy", 64'(issue_ready), 1);
      if (k == 3) begin
        chk("cap_net_pend", 64'(pending_cnt), 3);
        chk("cap_net_busy", 64'(busy), 64'h58);
      end
      tick();
    end
    idle();
    mid();
    tick();
    mid();
    chk("cap_drain_pend", 64'(pending_cnt), 1);
    chk("cap_drain_busy", 64'(busy), 64'h40);
    tick();
    lu(6, 64'h66);
    expect_wr(6, 64'h66, cyc + 1);
    mid();
    tick();
    idle();
    mid();
    tick();
    mid();
    chk("cap_end_pend", 64'(pending_cnt), 0);
    chk("cap_end_busy", 64'(busy), 0);
    tick();

    // Long op targeting x0.
    issue(0, 1);
    mid();
    chk("x0_issue_rdy", 64'(issue_ready), 1);
    tick();
    idle();
    mid();
    chk("x0_pend1", 64'(pending_cnt), 1);
    chk("x0_busy", 64'(busy), 0);
    tick();
    lu(0, 64'h55);
    mid();
    tick();
    idle();
    mid();
    chk("x0_regwrite", 64'(RegWrite), 0);
    tick();
    mid();
    chk("x0_pend0", 64'(pending_cnt), 0);
    tick();

    // Long write to a register that is not busy.
    lu(12, 64'hCC);
    expect_wr(12, 64'hCC, cyc + 1);
    mid();
    chk("err_pre", 64'(sb_err), 0);
    tick();
    idle();
    mid();
    chk("err_commit_cyc", 64'(sb_err), 0);
    tick();
    mid();
    chk("err_set", 64'(sb_err), 1);
    tick();
    for (int k = 0; k < 3; k++) tick();
    mid();
    chk("err_sticky", 64'(sb_err), 1);
    tick();

    // Reset while a long result sits in the hold slot.
    issue(8, 1);
    mid();
    tick();
    idle();
    alu(20, 64'h77);
    lu(8, 64'h88);
    expect_wr(20, 64'h77, cyc + 1);
    mid();
    tick();
    idle();
    reset = 1'b0;
    mid();
    chk("mrst_hold_full", 64'(lu_wb_ready), 0);
    tick();
    reset = 1'b1;
    mid();
    chk("mrst_lu_ready", 64'(lu_wb_ready), 1);
    chk("mrst_pend", 64'(pending_cnt), 0);
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_sb_err", 64'(sb_err), 0);
    chk("mrst_regwrite", 64'(RegWrite), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      mid();
      tick();
    end

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler and scoreboard for the single-write-port register file in the pipelined core. Arbitrates the one write port between the fixed-latency ALU writeback stream and a backpressurable long-latency unit (load/mul/div), buffering one deferred long-unit result. Tracks in-flight long-latency destinations and gates instruction issue on RAW/WAW hazards against them. Drives the register file's RegWrite/Writeregister/Writedata from registers on posedge; the register file captures them on the following negedge.

## Interface
- REG_W, 5, register address width (`REG_W from def.h)
- DATA_W, 64, write data width (`DATA_W from def.h)
- MAX_LONG, 4, max outstanding long-latency ops (1..15)

- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-low reset
- issue_valid  in  1  decode stage presents an instruction
- issue_rs1 / issue_rs2  in  REG_W  source register addresses
- issue_use_rs1 / issue_use_rs2  in  1  source actually read
- issue_rd  in  REG_W  destination register
- issue_long  in  1  destination produced by long-latency unit
- issue_ready  out  1  no hazard; issue handshake = issue_valid & issue_ready
- alu_wb_valid  in  1  ALU result this cycle (cannot stall)
- alu_wb_rd  in  REG_W, alu_wb_data  in  DATA_W
- lu_wb_valid  in  1  long-unit result offered
- lu_wb_rd  in  REG_W, lu_wb_data  in  DATA_W
- lu_wb_ready  out  1  long-unit handshake = lu_wb_valid & lu_wb_ready
- RegWrite  out  1  to register file write enable
- Writeregister  out  REG_W, Writedata  out  DATA_W
- busy  out  32  scoreboard vector, bit 0 always 0
- pending_cnt  out  4  outstanding long ops
- sb_err  out  1  sticky: long-unit write to a non-busy register

## Operation
- Scoreboard: busy[r] set on issue handshake with issue_long=1 and issue_rd!=0; pending_cnt increments on every long issue (including rd=0).
- issue_ready = !(use_rs1 & busy[rs1]) & !(use_rs2 & busy[rs2]) & !busy[rd] & !(issue_long & pending_cnt==MAX_LONG). Evaluated from registered busy/pending_cnt only; no same-cycle bypass of clears. issue_ready is combinational, independent of issue_valid.
- Write-select priority each cycle: ALU > hold > direct long unit. Sources enum: NONE, ALU, HOLD, LU.
- lu_wb_ready = !hold_full. On long-unit handshake: if alu_wb_valid, result goes to hold (hold_full<=1); else it is written directly.
- Hold FSM, 2 states: EMPTY -> FULL on long handshake coincident with alu_wb_valid; FULL -> EMPTY on first cycle with alu_wb_valid=0 (hold is written). No long handshake possible while FULL.
- Writes with rd=0 (either source) yield RegWrite=0; long-unit rd=0 still decrements pending_cnt.
- Commit of a long result (the cycle RegWrite output asserts for it, or rd=0 equivalent): clear busy[rd], decrement pending_cnt. If busy[rd]==0 at commit and rd!=0: set sb_err, write still performed.
- Set and clear of different registers in one cycle both apply; counter inc and dec in one cycle net to zero. Set/clear of the same register in one cycle cannot occur (set requires busy=0).

## Timing
- Reset (reset=0 at posedge): busy=0, pending_cnt=0, hold EMPTY, RegWrite=0, Writeregister=0, Writedata=0, sb_err=0. Outputs: issue_ready reflects cleared state (1 for any valid issue), lu_wb_ready=1. Mid-operation reset discards hold contents and all pending tracking; the long unit is reset concurrently.
- ALU write: alu_wb_valid at cycle N -> RegWrite=1 during N+1, captured by register file at negedge of N+1.
- Long direct: handshake at N (no ALU) -> RegWrite during N+1; busy cleared at posedge ending N+1.
- Long deferred: handshake at N with ALU -> RegWrite during first ALU-free cycle M+1 (M>=N+1).
- Dependent instruction sees issue_ready=1 in cycle N+2 after a direct long handshake at N.

## Structure
- Package regfile_sched_pkg: wb_src_e {WB_NONE, WB_ALU, WB_HOLD, WB_LU}; wb_req_t struct {valid, rd[REG_W], data[DATA_W]}; hold state enum {HOLD_EMPTY, HOLD_FULL}.
- Sub-module rf_scoreboard: busy vector, pending counter, sb_err, hazard check for issue_ready.
- Top: arbitration, hold register, registered write-port outputs.

## Test plan
- Reset: assert reset=0 two cycles with lu_wb_valid=1, alu_wb_valid=1 -> RegWrite=0, busy=0, pending_cnt=0, lu_wb_ready=1.
- RAW stall: long issue rd=5, then issue rs1=5 -> issue_ready=0 until lu_wb (rd=5, data=0xAA) handshake at N; issue_ready=1 at N+2; Writedata=0xAA, Writeregister=5 in N+1.
- Collision: alu_wb (rd=3, 0x11) and lu_wb (rd=7, 0x22) same cycle N -> x3 written N+1, lu_wb_ready=0 in N+1, x7 written N+2 if no ALU at N+1; ALU-every-cycle for 5 cycles delays x7 to cycle 6.
- Capacity: 4 long issues to rd 1..4 -> 5th long issue (rd=9) issue_ready=0, non-long rd=9 issue_ready=1; pending_cnt=4.
- x0: long issue rd=0 then lu_wb rd=0 -> RegWrite stays 0, busy unchanged, pending_cnt 1->0.
- Error: lu_wb rd=12 with busy[12]=0 -> sb_err=1 sticky until reset; x12 still written.
